alu_regfile: RTL

Operand-supply and write-back stage wrapped around the combinational ALU. It holds the eight-entry 16-bit register file and the Z/N/C flag register, and accepts one instruction per cycle over a valid/ready handshake. It drives registered operands and opcode into the ALU, and writes the ALU result and flags back one cycle later. It also provides a load port and a read port so the host can initialise and inspect registers.

---
 rtl/alu_regfile.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/alu_regfile.sv
// Operand-supply and write-back stage around an external combinational ALU:
// register file, Z/N/C flags, one-instruction-per-cycle EX/WB pipeline with bypass.
`ifndef B_WIDTH_DEF
`define B_WIDTH_DEF 16
`endif

module alu_regfile #(
    parameter int B_WIDTH = `B_WIDTH_DEF,
    parameter int NREGS   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         in_op,
    input  logic [2:0]         in_rd,
    input  logic [2:0]         in_rs,
    input  logic               ld_valid,
    input  logic [2:0]         ld_addr,
    input  logic [B_WIDTH-1:0] ld_data,
    input  logic [2:0]         rd_addr,
    output logic [B_WIDTH-1:0] rd_data,
    output logic [3:0]         alu_op,
    output logic [B_WIDTH-1:0] alu_la,
    output logic [B_WIDTH-1:0] alu_ha,
    output logic [B_WIDTH-1:0] alu_lb,
    output logic [B_WIDTH-1:0] alu_hb,
    input  logic [B_WIDTH-1:0] alu_lc,
    input  logic [B_WIDTH-1:0] alu_hc,
    input  logic               alu_zr,
    input  logic               alu_ng,
    input  logic               alu_carry,
    output logic               wb_valid,
    output logic [2:0]         flags
);

    localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;
    typedef logic [AW-1:0] idx_t;

    // Handshake: an instruction is taken on a rising edge when in_valid && in_ready.
    // in_ready drops whenever the host load port is busy; nothing else stalls.

    function automatic idx_t to_idx(input logic [2:0] r);
        return idx_t'({29'd0, r} & 32'(NREGS - 1));
    endfunction

    logic [B_WIDTH-1:0] rf_q   [NREGS];
    logic [B_WIDTH-1:0] rf_d   [NREGS];
    logic [B_WIDTH-1:0] rf_byp [NREGS];
    logic [NREGS-1:0]   wb_hit;

    logic               ex_valid_q;
    logic               ex_dbl_q;
    idx_t               ex_lo_q;
    idx_t               ex_hi_q;
    logic [3:0]         alu_op_q;
    logic [B_WIDTH-1:0] alu_la_q;
    logic [B_WIDTH-1:0] alu_ha_q;
    logic [B_WIDTH-1:0] alu_lb_q;
    logic [B_WIDTH-1:0] alu_hb_q;
    logic               wb_valid_q;
    logic [2:0]         flags_q;

    logic               accept;
    logic               in_dbl;
    idx_t               rd_idx;
    idx_t               rs_idx;
    idx_t               a_lo;
    idx_t               a_hi;
    idx_t               b_lo;
    idx_t               b_hi;
    idx_t               ld_idx;

    assign in_ready = !ld_valid;
    assign accept   = in_valid && in_ready;
    assign in_dbl   = in_op[3];
    assign rd_idx   = to_idx(in_rd);
    assign rs_idx   = to_idx(in_rs);
    assign ld_idx   = to_idx(ld_addr);
    assign a_lo     = in_dbl ? (rd_idx & ~idx_t'(1)) : rd_idx;
    assign a_hi     = rd_idx | idx_t'(1);
    assign b_lo     = in_dbl ? (rs_idx & ~idx_t'(1)) : rs_idx;
    assign b_hi     = rs_idx | idx_t'(1);

    // rf_byp is the register file as it will look after this edge's write-back;
    // operand capture reads it so dependent instructions never stall.
    always_comb begin
        wb_hit = '0;
        for (int i = 0; i < NREGS; i++) begin
            rf_byp[i] = rf_q[i];
            if (ex_valid_q && idx_t'(i) == ex_lo_q) begin
                rf_byp[i] = alu_lc;
                wb_hit[i] = 1'b1;
            end
            if (ex_valid_q && ex_dbl_q && idx_t'(i) == ex_hi_q) begin
                rf_byp[i] = alu_hc;
                wb_hit[i] = 1'b1;
            end
            rf_d[i] = rf_byp[i];
            if (ld_valid && idx_t'(i) == ld_idx && !wb_hit[i]) begin
                rf_d[i] = ld_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                rf_q[i] <= '0;
            end
            ex_valid_q <= 1'b0;
            ex_dbl_q   <= 1'b0;
            ex_lo_q    <= '0;
            ex_hi_q    <= '0;
            alu_op_q   <= '0;
            alu_la_q   <= '0;
            alu_ha_q   <= '0;
            alu_lb_q   <= '0;
            alu_hb_q   <= '0;
            wb_valid_q <= 1'b0;
            flags_q    <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                rf_q[i] <= rf_d[i];
            end
            wb_valid_q <= ex_valid_q;
            if (ex_valid_q) begin
                flags_q <= {alu_carry, alu_ng, alu_zr};
            end
            ex_valid_q <= accept;
            // Operands hold their last values while EX is idle.
            if (accept) begin
                ex_dbl_q <= in_dbl;
                ex_lo_q  <= a_lo;
                ex_hi_q  <= a_hi;
                alu_op_q <= in_op;
                alu_la_q <= rf_byp[a_lo];
                alu_ha_q <= in_dbl ? rf_byp[a_hi] : '0;
                alu_lb_q <= rf_byp[b_lo];
                alu_hb_q <= in_dbl ? rf_byp[b_hi] : '0;
            end
        end
    end

    assign rd_data  = rf_q[to_idx(rd_addr)];
    assign alu_op   = alu_op_q;
    assign alu_la   = alu_la_q;
    assign alu_ha   = alu_ha_q;
    assign alu_lb   = alu_lb_q;
    assign alu_hb   = alu_hb_q;
    assign wb_valid = wb_valid_q;
    assign flags    = flags_q;

endmodule
